// File: rtl/serial_word_transmitter_pkg.sv
// Shared encodings for the serial word transmitter: FSM states and line levels.
package serial_word_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_word_transmitter_if.sv
// Handshake and line signals between the controlling FSM and the transmitter.
interface serial_word_transmitter_if #(
  parameter int WORD_LENGTH = 4
);
  logic                   start;
  logic [WORD_LENGTH-1:0] Data_Input;
  logic                   Serial_Output;
  logic                   busy;
  logic                   done;

  modport master (
    output start, Data_Input,
    input  Serial_Output, busy, done
  );

  modport slave (
    input  start, Data_Input,
    output Serial_Output, busy, done
  );
endinterface

// File: rtl/serial_word_transmitter_bit_timer.sv
// Modulo-CYCLES_PER_BIT counter; tick marks the last cycle of each bit period.
module serial_word_transmitter_bit_timer #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  // next count: clear wins, otherwise wrap at the terminal tick
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable) begin
      if (tick) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, stop bit.
module serial_word_transmitter
  import serial_word_transmitter_pkg::*;
#(
  parameter int WORD_LENGTH    = 4,
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_word_transmitter_if.slave  bus
);

  localparam int IW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_LENGTH - 1);

  tx_state_e              state_q, state_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timer_clear_s;
  logic                   timer_en_s;
  logic                   tick_s;

  assign timer_en_s = (state_q != IDLE);

  serial_word_transmitter_bit_timer #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT)
  ) bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .tick   (tick_s)
  );

  // next-state logic; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    timer_clear_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d       = bus.Data_Input;
          idx_d         = {IW{1'b0}};
          timer_clear_s = 1'b1;
          state_d       = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_d = shift_q >> 32'd1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      IDLE:    begin serial_d = IDLE_LEVEL;  busy_d = 1'b0; end
      START:   begin serial_d = START_LEVEL; busy_d = 1'b1; end
      DATA:    begin serial_d = shift_d[0];  busy_d = 1'b1; end
      STOP:    begin serial_d = IDLE_LEVEL;  busy_d = 1'b1; end
      default: begin serial_d = IDLE_LEVEL;  busy_d = 1'b0; end
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= {WORD_LENGTH{1'b0}};
      idx_q    <= {IW{1'b0}};
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Serial_Output = serial_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed bench: WORD_LENGTH=4/CYCLES_PER_BIT=2 instance plus a 1/1 width-sweep instance.
module tb_serial_word_transmitter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_word_transmitter_if #(.WORD_LENGTH(4)) if0 ();
  serial_word_transmitter_if #(.WORD_LENGTH(1)) if1 ();

  serial_word_transmitter #(.WORD_LENGTH(4), .CYCLES_PER_BIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  serial_word_transmitter #(.WORD_LENGTH(1), .CYCLES_PER_BIT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // pat[i] is the expected line level in cycle i+1 after acceptance
  task automatic frame_check(input string tag, input logic [11:0] pat,
                             input logic nxt_start, input logic [3:0] nxt_data);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk({tag, "_line"}, 32'(if0.Serial_Output), 32'(pat[i]));
      chk({tag, "_busy"}, 32'(if0.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(if0.done), 32'd0);
      if (i == 0) begin
        if0.start      = nxt_start;
        if0.Data_Input = nxt_data;
      end
    end
  endtask

  task automatic done_check(input string tag, input logic nxt_start, input logic [3:0] nxt_data);
    @(negedge clk);
    chk({tag, "_done"}, 32'(if0.done), 32'd1);
    chk({tag, "_done_busy"}, 32'(if0.busy), 32'd0);
    chk({tag, "_done_line"}, 32'(if0.Serial_Output), 32'd1);
    if0.start      = nxt_start;
    if0.Data_Input = nxt_data;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_line"}, 32'(if0.Serial_Output), 32'd1);
    chk({tag, "_busy"}, 32'(if0.busy), 32'd0);
    chk({tag, "_done"}, 32'(if0.done), 32'd0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    if0.start      = 1'b0;
    if0.Data_Input = 4'b0000;
    if1.start      = 1'b0;
    if1.Data_Input = 1'b0;

    // reset and idle
    repeat (3) idle_check("in_reset");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) idle_check("idle");
    chk("idle1_line", 32'(if1.Serial_Output), 32'd1);
    chk("idle1_busy", 32'(if1.busy), 32'd0);

    // single frame of 4'b1011
    if0.start      = 1'b1;
    if0.Data_Input = 4'b1011;
    frame_check("single", 12'b1111_0011_1100, 1'b0, 4'b1011);
    done_check("single", 1'b0, 4'b0000);
    idle_check("single_after");

    // start held and data changed mid-frame, then 4'b0000 accepted in the done cycle
    if0.start      = 1'b1;
    if0.Data_Input = 4'b1011;
    frame_check("ignore", 12'b1111_0011_1100, 1'b1, 4'b0000);
    done_check("ignore", 1'b1, 4'b0000);
    frame_check("ignore2", 12'b1100_0000_0000, 1'b0, 4'b0000);
    done_check("ignore2", 1'b0, 4'b0000);
    idle_check("ignore_after");

    // back-to-back 4'h5 then 4'hA
    if0.start      = 1'b1;
    if0.Data_Input = 4'h5;
    frame_check("b2b5", 12'b1100_1100_1100, 1'b0, 4'h5);
    done_check("b2b5", 1'b1, 4'hA);
    frame_check("b2bA", 12'b1111_0011_0000, 1'b0, 4'hA);
    done_check("b2bA", 1'b0, 4'h0);
    idle_check("b2b_after");

    // reset during DATA bit 2 of 4'b1011 (bit 2 is 0 on the line)
    if0.start      = 1'b1;
    if0.Data_Input = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if0.start = 1'b0;
    end
    chk("rst_pre_line", 32'(if0.Serial_Output), 32'd0);
    chk("rst_pre_busy", 32'(if0.busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_line", 32'(if0.Serial_Output), 32'd1);
    chk("rst_async_busy", 32'(if0.busy), 32'd0);
    chk("rst_async_done", 32'(if0.done), 32'd0);
    repeat (3) idle_check("rst_hold");
    reset          = 1'b1;
    if0.start      = 1'b1;
    if0.Data_Input = 4'hF;
    frame_check("rstF", 12'b1111_1111_1100, 1'b0, 4'h0);
    done_check("rstF", 1'b0, 4'h0);

    // width sweep: WORD_LENGTH=1, CYCLES_PER_BIT=1, data 1 -> line 0,1,1
    if1.start      = 1'b1;
    if1.Data_Input = 1'b1;
    @(negedge clk);
    chk("w1_start_line", 32'(if1.Serial_Output), 32'd0);
    chk("w1_start_busy", 32'(if1.busy), 32'd1);
    if1.start = 1'b0;
    @(negedge clk);
    chk("w1_data_line", 32'(if1.Serial_Output), 32'd1);
    chk("w1_data_busy", 32'(if1.busy), 32'd1);
    @(negedge clk);
    chk("w1_stop_line", 32'(if1.Serial_Output), 32'd1);
    chk("w1_stop_busy", 32'(if1.busy), 32'd1);
    chk("w1_stop_nodone", 32'(if1.done), 32'd0);
    @(negedge clk);
    chk("w1_done", 32'(if1.done), 32'd1);
    chk("w1_done_busy", 32'(if1.busy), 32'd0);
    @(negedge clk);
    chk("w1_after_done", 32'(if1.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
